rv32_multicycle_ctrl: RTL and testbench
=======================================

Name: rv32_multicycle_ctrl

Overview:
- Multi-cycle RV32I control FSM. It sequences the fetch / decode / execute / memory / writeback steps of the shared datapath.
- Consumes the opcode and funct3 fields of the instruction register, plus the branch-compare result and the memory handshake.
- Drives mux selects, register and PC write enables, IR load and memory requests.
- Counts retired instructions and halts on illegal or SYSTEM instructions.

Parameters:
- CNT_WIDTH, 64, width of the retired-instruction counter.
- RESET_PC_SEL, 3, pc_sel code driven during RESET so the datapath loads the reset vector.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- opcode  input  7  opcode field of the instruction register; valid from DECODE until the next IR load.
- funct3  input  3  funct3 field of the instruction register; same validity as opcode.
- branch_taken  input  1  comparator result for the current branch; valid in EXECUTE.
- mem_ready  input  1  memory completes the current request this cycle.
- mem_req  output  1  memory request; held high until mem_ready.
- mem_we  output  1  write request (stores only).
- mem_addr_sel  output  1  0 = PC, 1 = ALU result.
- ir_load  output  1  load IR from memory read data.
- alu_a_sel  output  2  0 = rs1, 1 = PC, 2 = zero.
- alu_b_sel  output  1  0 = rs2, 1 = immediate.
- imm_sel  output  3  0 = I, 1 = S, 2 = B, 3 = U, 4 = J.
- reg_write  output  1  register-file write enable.
- wb_sel  output  2  0 = ALU, 1 = memory data, 2 = PC+4.
- pc_write  output  1  PC load enable.
- pc_sel  output  2  0 = PC+4, 1 = ALU result, 2 = ALU result with bit 0 cleared, 3 = reset vector.
- trap  output  1  core halted.
- instret  output  CNT_WIDTH  retired-instruction count.

Behaviour:
- States: RESET, FETCH, DECODE, EXECUTE, MEM, WRITEBACK, HALT.
- State register, instret and trap are flops. All other outputs are combinational from the state and the current opcode/funct3.
- Reset (async assert): state = RESET, instret = 0, trap = 0, all enables and requests 0.
- RESET state: pc_write = 1 with pc_sel = RESET_PC_SEL for one cycle, then go to FETCH.
- FETCH:
  - Drive mem_req = 1, mem_addr_sel = 0.
  - Stay while mem_ready = 0.
  - On mem_ready: ir_load = 1 in the same cycle; next state is DECODE.
- DECODE: legality check.
  - Illegal cases: unknown opcode; SYSTEM; JALR with funct3 != 0; BRANCH with funct3 2 or 3; LOAD with funct3 3, 6 or 7; STORE with funct3 >= 3.
  - Illegal goes to HALT and sets trap.
  - MISC-MEM (FENCE) is a no-op and goes to WRITEBACK with reg_write = 0.
  - All others go to EXECUTE.
- EXECUTE selects, per opcode:
  - LUI: a = zero, b = imm, imm U.
  - AUIPC: a = PC, b = imm, imm U.
  - OP-IMM: a = rs1, b = imm, imm I.
  - OP: a = rs1, b = rs2.
  - LOAD: a = rs1, b = imm, imm I.
  - STORE: a = rs1, b = imm, imm S.
  - JAL: a = PC, b = imm, imm J.
  - JALR: a = rs1, b = imm, imm I.
  - BRANCH: a = PC, b = imm, imm B.
- EXECUTE transitions:
  - BRANCH: pc_write = 1, pc_sel = 1 if branch_taken else 0; instret increments; next state FETCH.
  - LOAD and STORE: next state MEM.
  - Everything else: next state WRITEBACK.
- MEM:
  - mem_req = 1, mem_addr_sel = 1, mem_we = 1 for stores; selects held from EXECUTE.
  - Wait for mem_ready.
  - Load: next state WRITEBACK.
  - Store: pc_write = 1, pc_sel = 0, instret increments, next state FETCH.
- WRITEBACK:
  - reg_write = 1, except FENCE.
  - wb_sel = 1 for LOAD, 2 for JAL/JALR, else 0.
  - pc_write = 1; pc_sel = 1 for JAL, 2 for JALR, else 0.
  - instret increments; next state FETCH.
- The datapath latches the ALU result at the end of EXECUTE, so the JAL/JALR target stays stable through WRITEBACK.
- HALT: all enables and requests 0, trap = 1. Exited only by reset.
- rd = x0 masking is the register file's job, not this block's.
- Memory request:
  - mem_req never drops before mem_ready.
  - mem_ready with mem_req low is ignored.
  - Reset during a pending request drops mem_req immediately, asynchronously.
- instret wraps modulo 2^CNT_WIDTH and increments at most once per instruction.
- Latency in cycles, with zero-wait memory and including FETCH:
  - ALU, LUI, AUIPC and jumps: 4.
  - Branch: 3.
  - Store: 4.
  - Load: 5.
  - Each memory wait cycle adds 1.

Decomposition:
- The shared opcode header holds the RV32I opcode constants, the state encodings and the select codes for alu_a_sel, alu_b_sel, imm_sel, wb_sel and pc_sel, so datapath and controller agree.
- One natural sub-module: rv32_insn_legal. It is the combinational legality check of opcode and funct3, reused later by the trap logic.

Test Plan:
- Reset, then ADDI (0x00500093) with zero-wait memory:
  - RESET, FETCH, DECODE, EXECUTE, WRITEBACK.
  - reg_write = 1, wb_sel = 0, imm_sel = 0, alu_b_sel = 1 in the expected cycles.
  - instret = 1.
- LW with mem_ready delayed 3 cycles in MEM:
  - mem_req is held high for 4 cycles with mem_addr_sel = 1 and mem_we = 0.
  - WRITEBACK follows with wb_sel = 1.
- BEQ with branch_taken = 1, then with branch_taken = 0:
  - EXECUTE asserts pc_write, with pc_sel 1 and 0 respectively.
  - No WRITEBACK state; instret increments once each.
- JALR (funct3 = 0):
  - WRITEBACK asserts reg_write, wb_sel = 2, pc_sel = 2.
  - The same opcode with funct3 = 1 goes to HALT with trap = 1; instret is unchanged.
- ECALL (0x00000073) and opcode 0x7F: both trap; the FSM stays in HALT for 20 or more cycles until rst_n is asserted.
- Deassert rst_n while mem_req is high in FETCH:
  - mem_req goes low asynchronously.
  - After release, one RESET cycle with pc_write = 1 and pc_sel = 3, then FETCH.

Source files
------------

// File: rtl/rv32_multicycle_ctrl_pkg.sv
// Shared RV32I constants: opcodes, controller state encoding and datapath select codes.
// Datapath and controller both import this so their mux encodings cannot drift apart.
package rv32_multicycle_ctrl_pkg;

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  typedef enum logic [2:0] {
    ST_RESET,
    ST_FETCH,
    ST_DECODE,
    ST_EXECUTE,
    ST_MEM,
    ST_WRITEBACK,
    ST_HALT
  } state_t;

  localparam logic [1:0] ALU_A_RS1  = 2'd0;
  localparam logic [1:0] ALU_A_PC   = 2'd1;
  localparam logic [1:0] ALU_A_ZERO = 2'd2;

  localparam logic ALU_B_RS2 = 1'b0;
  localparam logic ALU_B_IMM = 1'b1;

  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_U = 3'd3;
  localparam logic [2:0] IMM_J = 3'd4;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;

  localparam logic [1:0] PC_PLUS4     = 2'd0;
  localparam logic [1:0] PC_ALU       = 2'd1;
  localparam logic [1:0] PC_ALU_ALIGN = 2'd2;
  localparam logic [1:0] PC_RESET     = 2'd3;

endpackage

// File: rtl/rv32_multicycle_ctrl_if.sv
// Controller <-> datapath/memory bundle; master is the controller, slave the datapath side.
interface rv32_multicycle_ctrl_if #(
  parameter int CNT_WIDTH = 64
);
  logic [6:0]           opcode;
  logic [2:0]           funct3;
  logic                 branch_taken;
  logic                 mem_ready;
  logic                 mem_req;
  logic                 mem_we;
  logic                 mem_addr_sel;
  logic                 ir_load;
  logic [1:0]           alu_a_sel;
  logic                 alu_b_sel;
  logic [2:0]           imm_sel;
  logic                 reg_write;
  logic [1:0]           wb_sel;
  logic                 pc_write;
  logic [1:0]           pc_sel;
  logic                 trap;
  logic [CNT_WIDTH-1:0] instret;

  modport master (
    input  opcode, funct3, branch_taken, mem_ready,
    output mem_req, mem_we, mem_addr_sel, ir_load, alu_a_sel, alu_b_sel, imm_sel,
           reg_write, wb_sel, pc_write, pc_sel, trap, instret
  );

  modport slave (
    output opcode, funct3, branch_taken, mem_ready,
    input  mem_req, mem_we, mem_addr_sel, ir_load, alu_a_sel, alu_b_sel, imm_sel,
           reg_write, wb_sel, pc_write, pc_sel, trap, instret
  );
endinterface

// File: rtl/rv32_insn_legal.sv
// Combinational RV32I legality check on opcode/funct3 (funct7 is not examined).
module rv32_insn_legal
  import rv32_multicycle_ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  output logic       legal
);

  always_comb begin
    legal = 1'b0;
    case (opcode)
      OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_OP_IMM, OPC_OP, OPC_MISC_MEM: legal = 1'b1;
      OPC_JALR:   legal = (funct3 == 3'd0);
      OPC_BRANCH: legal = (funct3 != 3'd2) && (funct3 != 3'd3);
      OPC_LOAD:   legal = (funct3 != 3'd3) && (funct3 != 3'd6) && (funct3 != 3'd7);
      OPC_STORE:  legal = (funct3 < 3'd3);
      default:    legal = 1'b0;  // SYSTEM lands here too: the core halts on it
    endcase
  end

endmodule

// File: rtl/rv32_multicycle_ctrl.sv
// Multi-cycle RV32I control FSM: sequences fetch/decode/execute/mem/writeback,
// counts retired instructions and halts on illegal or SYSTEM instructions.
module rv32_multicycle_ctrl
  import rv32_multicycle_ctrl_pkg::*;
#(
  parameter int         CNT_WIDTH    = 64,
  parameter logic [1:0] RESET_PC_SEL = 2'd3
) (
  input logic                    clk,
  input logic                    rst_n,
  rv32_multicycle_ctrl_if.master bus
);

  state_t               state_reg, state_next;
  logic [CNT_WIDTH-1:0] instret_reg;
  logic                 trap_reg;
  logic                 retire, trap_set, legal;
  logic [1:0]           op_a_sel;
  logic                 op_b_sel;
  logic [2:0]           op_imm_sel;

  rv32_insn_legal u_legal (
    .opcode (bus.opcode),
    .funct3 (bus.funct3),
    .legal  (legal)
  );

  // Operand selects per opcode; applied in EXECUTE and held through MEM.
  always_comb begin
    op_a_sel   = ALU_A_RS1;
    op_b_sel   = ALU_B_IMM;
    op_imm_sel = IMM_I;
    case (bus.opcode)
      OPC_LUI:    begin op_a_sel = ALU_A_ZERO; op_imm_sel = IMM_U; end
      OPC_AUIPC:  begin op_a_sel = ALU_A_PC;   op_imm_sel = IMM_U; end
      OPC_OP:     op_b_sel = ALU_B_RS2;
      OPC_STORE:  op_imm_sel = IMM_S;
      OPC_JAL:    begin op_a_sel = ALU_A_PC;   op_imm_sel = IMM_J; end
      OPC_BRANCH: begin op_a_sel = ALU_A_PC;   op_imm_sel = IMM_B; end
      default:    ;
    endcase
  end

  always_comb begin
    state_next       = state_reg;
    retire           = 1'b0;
    trap_set         = 1'b0;
    bus.mem_req      = 1'b0;
    bus.mem_we       = 1'b0;
    bus.mem_addr_sel = 1'b0;
    bus.ir_load      = 1'b0;
    bus.alu_a_sel    = ALU_A_RS1;
    bus.alu_b_sel    = ALU_B_RS2;
    bus.imm_sel      = IMM_I;
    bus.reg_write    = 1'b0;
    bus.wb_sel       = WB_ALU;
    bus.pc_write     = 1'b0;
    bus.pc_sel       = PC_PLUS4;
    case (state_reg)
      ST_RESET: begin
        // State register sits in RESET while rst_n is low; only load the vector once released.
        bus.pc_write = rst_n;
        bus.pc_sel   = RESET_PC_SEL;
        state_next   = ST_FETCH;
      end
      ST_FETCH: begin
        bus.mem_req = 1'b1;
        if (bus.mem_ready) begin
          bus.ir_load = 1'b1;
          state_next  = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (!legal) begin
          trap_set   = 1'b1;
          state_next = ST_HALT;
        end else if (bus.opcode == OPC_MISC_MEM) begin
          state_next = ST_WRITEBACK;
        end else begin
          state_next = ST_EXECUTE;
        end
      end
      ST_EXECUTE: begin
        bus.alu_a_sel = op_a_sel;
        bus.alu_b_sel = op_b_sel;
        bus.imm_sel   = op_imm_sel;
        if (bus.opcode == OPC_BRANCH) begin
          bus.pc_write = 1'b1;
          bus.pc_sel   = bus.branch_taken ? PC_ALU : PC_PLUS4;
          retire       = 1'b1;
          state_next   = ST_FETCH;
        end else if (bus.opcode == OPC_LOAD || bus.opcode == OPC_STORE) begin
          state_next = ST_MEM;
        end else begin
          state_next = ST_WRITEBACK;
        end
      end
      ST_MEM: begin
        bus.alu_a_sel    = op_a_sel;
        bus.alu_b_sel    = op_b_sel;
        bus.imm_sel      = op_imm_sel;
        bus.mem_req      = 1'b1;
        bus.mem_addr_sel = 1'b1;
        bus.mem_we       = (bus.opcode == OPC_STORE);
        if (bus.mem_ready) begin
          if (bus.opcode == OPC_STORE) begin
            bus.pc_write = 1'b1;
            retire       = 1'b1;
            state_next   = ST_FETCH;
          end else begin
            state_next = ST_WRITEBACK;
          end
        end
      end
      ST_WRITEBACK: begin
        bus.reg_write = (bus.opcode != OPC_MISC_MEM);
        bus.pc_write  = 1'b1;
        retire        = 1'b1;
        state_next    = ST_FETCH;
        case (bus.opcode)
          OPC_LOAD: bus.wb_sel = WB_MEM;
          OPC_JAL:  begin bus.wb_sel = WB_PC4; bus.pc_sel = PC_ALU; end
          OPC_JALR: begin bus.wb_sel = WB_PC4; bus.pc_sel = PC_ALU_ALIGN; end
          default:  ;
        endcase
      end
      ST_HALT: state_next = ST_HALT;
      default: state_next = ST_HALT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= ST_RESET;
      instret_reg <= '0;
      trap_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (retire) instret_reg <= instret_reg + CNT_WIDTH'(1);
      if (trap_set) trap_reg <= 1'b1;
    end
  end

  assign bus.trap    = trap_reg;
  assign bus.instret = instret_reg;

endmodule

// File: tb/tb_rv32_multicycle_ctrl.sv
// Directed bench for rv32_multicycle_ctrl: per-cycle output vectors against hand-computed values.
module tb_rv32_multicycle_ctrl;

  localparam int CW = 64;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad   = 0;

  rv32_multicycle_ctrl_if #(.CNT_WIDTH(CW)) bus ();

  rv32_multicycle_ctrl #(
    .CNT_WIDTH    (CW),
    .RESET_PC_SEL (2'd3)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // {mem_req, mem_we, mem_addr_sel, ir_load, alu_a_sel, alu_b_sel, imm_sel,
  //  reg_write, wb_sel, pc_write, pc_sel, trap}
  logic [16:0] outs;
  assign outs = {bus.mem_req, bus.mem_we, bus.mem_addr_sel, bus.ir_load, bus.alu_a_sel,
                 bus.alu_b_sel, bus.imm_sel, bus.reg_write, bus.wb_sel, bus.pc_write,
                 bus.pc_sel, bus.trap};

  function automatic logic [16:0] v(input logic req, input logic we, input logic ms,
                                    input logic irl, input logic [1:0] a, input logic b,
                                    input logic [2:0] imm, input logic rw, input logic [1:0] wb,
                                    input logic pcw, input logic [1:0] pcs, input logic tr);
    return {req, we, ms, irl, a, b, imm, rw, wb, pcw, pcs, tr};
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Called at posedge+1: drive this cycle's inputs, check outputs, advance one cycle.
  task automatic cyc(input string tag, input logic rdy, input logic tk, input logic [16:0] exp);
    bus.mem_ready    = rdy;
    bus.branch_taken = tk;
    #1;
    check(tag, 64'(outs), 64'(exp));
    @(posedge clk);
    #1;
  endtask

  task automatic fetch_dec(input logic [6:0] op, input logic [2:0] f3);
    bus.opcode = op;
    bus.funct3 = f3;
    cyc("fetch",  1'b1, 1'b0, v(1,0,0,1, 2'd0,0,3'd0, 0,2'd0, 0,2'd0, 0));
    cyc("decode", 1'b0, 1'b0, 17'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.mem_ready = 1'b0;
    @(posedge clk);
    #1;
    check("rst_outs",    64'(outs), 64'(v(0,0,0,0, 2'd0,0,3'd0, 0,2'd0, 0,2'd3, 0)));
    check("rst_instret", bus.instret, 64'd0);
    rst_n = 1'b1;
    cyc("reset_cycle", 1'b0, 1'b0, v(0,0,0,0, 2'd0,0,3'd0, 0,2'd0, 1,2'd3, 0));
  endtask

  task automatic halt_cycles(input string tag);
    for (int i = 0; i < 22; i++)
      cyc(tag, 1'(i % 2), 1'b0, v(0,0,0,0, 2'd0,0,3'd0, 0,2'd0, 0,2'd0, 1));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] saved;
    bus.opcode = 7'h13; bus.funct3 = 3'd0; bus.branch_taken = 1'b0; bus.mem_ready = 1'b0;

    do_reset();

    // ADDI x1, x0, 5
    fetch_dec(7'h13, 3'd0);
    cyc("addi.ex", 0, 0, v(0,0,0,0, 2'd0,1,3'd0, 0,2'd0, 0,2'd0, 0));
    cyc("addi.wb", 0, 0, v(0,0,0,0, 2'd0,0,3'd0, 1,2'd0, 1,2'd0, 0));
    check("addi.instret", bus.instret, 64'd1);
    $display("txn addi instret=%0d", bus.instret);

    // LW with three memory wait cycles
    fetch_dec(7'h03, 3'd2);
    cyc("lw.ex", 0, 0, v(0,0,0,0, 2'd0,1,3'd0, 0,2'd0, 0,2'd0, 0));
    for (int i = 0; i < 3; i++)
      cyc("lw.memwait", 0, 0, v(1,0,1,0, 2'd0,1,3'd0, 0,2'd0, 0,2'd0, 0));
    cyc("lw.memdone", 1, 0, v(1,0,1,0, 2'd0,1,3'd0, 0,2'd0, 0,2'd0, 0));
    cyc("lw.wb",      0, 0, v(0,0,0,0, 2'd0,0,3'd0, 1,2'd1, 1,2'd0, 0));
    check("lw.instret", bus.instret, 64'd2);
    $display("txn lw instret=%0d", bus.instret);

    // BEQ taken then not taken: next cycle must already be FETCH
    fetch_dec(7'h63, 3'd0);
    cyc("beq_t.ex", 0, 1, v(0,0,0,0, 2'd1,1,3'd2, 0,2'd0, 1,2'd1, 0));
    check("beq_t.instret", bus.instret, 64'd3);
    $display("txn beq_taken instret=%0d", bus.instret);
    fetch_dec(7'h63, 3'd0);
    cyc("beq_n.ex", 0, 0, v(0,0,0,0, 2'd1,1,3'd2, 0,2'd0, 1,2'd0, 0));
    check("beq_n.instret", bus.instret, 64'd4);
    $display("txn beq_not_taken instret=%0d", bus.instret);

    // SW with one fetch wait cycle
    bus.opcode = 7'h23; bus.funct3 = 3'd2;
    cyc("sw.fetchwait", 0, 0, v(1,0,0,0, 2'd0,0,3'd0, 0,2'd0, 0,2'd0, 0));
    fetch_dec(7'h23, 3'd2);
    cyc("sw.ex",  0, 0, v(0,0,0,0, 2'd0,1,3'd1, 0,2'd0, 0,2'd0, 0));
    cyc("sw.mem", 1, 0, v(1,1,1,0, 2'd0,1,3'd1, 0,2'd0, 1,2'd0, 0));
    check("sw.instret", bus.instret, 64'd5);
    $display("txn sw instret=%0d", bus.instret);

    // JAL
    fetch_dec(7'h6F, 3'd0);
    cyc("jal.ex", 0, 0, v(0,0,0,0, 2'd1,1,3'd4, 0,2'd0, 0,2'd0, 0));
    cyc("jal.wb", 0, 0, v(0,0,0,0, 2'd0,0,3'd0, 1,2'd2, 1,2'd1, 0));
    $display("txn jal instret=%0d", bus.instret);

    // JALR funct3=0
    fetch_dec(7'h67, 3'd0);
    cyc("jalr.ex", 0, 0, v(0,0,0,0, 2'd0,1,3'd0, 0,2'd0, 0,2'd0, 0));
    cyc("jalr.wb", 0, 0, v(0,0,0,0, 2'd0,0,3'd0, 1,2'd2, 1,2'd2, 0));
    $display("txn jalr instret=%0d", bus.instret);

    // FENCE: straight to WRITEBACK without a register write
    fetch_dec(7'h0F, 3'd0);
    cyc("fence.wb", 0, 0, v(0,0,0,0, 2'd0,0,3'd0, 0,2'd0, 1,2'd0, 0));
    $display("txn fence instret=%0d", bus.instret);

    // LUI and OP
    fetch_dec(7'h37, 3'd0);
    cyc("lui.ex", 0, 0, v(0,0,0,0, 2'd2,1,3'd3, 0,2'd0, 0,2'd0, 0));
    cyc("lui.wb", 0, 0, v(0,0,0,0, 2'd0,0,3'd0, 1,2'd0, 1,2'd0, 0));
    fetch_dec(7'h33, 3'd0);
    cyc("op.ex", 0, 0, v(0,0,0,0, 2'd0,0,3'd0, 0,2'd0, 0,2'd0, 0));
    cyc("op.wb", 0, 0, v(0,0,0,0, 2'd0,0,3'd0, 1,2'd0, 1,2'd0, 0));
    check("op.instret", bus.instret, 64'd10);
    $display("txn lui_op instret=%0d", bus.instret);

    // JALR funct3=1 is illegal: HALT, trap, count frozen
    saved = 64'd10;
    fetch_dec(7'h67, 3'd1);
    halt_cycles("jalr_bad.halt");
    check("jalr_bad.instret", bus.instret, saved);
    $display("txn jalr_illegal trap=%0b instret=%0d", bus.trap, bus.instret);

    // ECALL
    do_reset();
    fetch_dec(7'h73, 3'd0);
    halt_cycles("ecall.halt");
    check("ecall.instret", bus.instret, 64'd0);
    $display("txn ecall trap=%0b", bus.trap);

    // Unknown opcode 0x7F
    do_reset();
    fetch_dec(7'h7F, 3'd0);
    halt_cycles("op7f.halt");
    $display("txn opcode_7f trap=%0b", bus.trap);

    // Reset asserted mid-FETCH with a pending request
    do_reset();
    bus.mem_ready = 1'b0;
    #1;
    check("async.pending", 64'(outs), 64'(v(1,0,0,0, 2'd0,0,3'd0, 0,2'd0, 0,2'd0, 0)));
    #2;
    rst_n = 1'b0;
    #1;
    check("async.dropped", 64'(outs), 64'(v(0,0,0,0, 2'd0,0,3'd0, 0,2'd0, 0,2'd3, 0)));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc("async.reset_cycle", 0, 0, v(0,0,0,0, 2'd0,0,3'd0, 0,2'd0, 1,2'd3, 0));
    cyc("async.fetch",       1, 0, v(1,0,0,1, 2'd0,0,3'd0, 0,2'd0, 0,2'd0, 0));
    $display("txn async_reset instret=%0d", bus.instret);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
